// File: rtl/delay_lap_calib.sv
// Measures ref-to-dly sync edge latency in clk cycles and publishes it once
// LOCK_COUNT consecutive measurements agree.
module delay_lap_calib #(
    parameter int unsigned MAX_DELAY_LAPS = 640,
    parameter int unsigned LAP_W          = 10,
    parameter int unsigned LOCK_COUNT     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_ref_sync,
    input  logic             i_dly_sync,
    output logic [LAP_W-1:0] o_delaylap,
    output logic             o_locked,
    output logic             o_busy,
    output logic             o_err_tmo
);

    localparam int unsigned CNT_W = LAP_W + 1;
    localparam int unsigned MC_W  = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, EVAL} state_t;

    state_t           state;
    logic             ref_q;
    logic             ref_p;
    logic             dly_q;
    logic             dly_p;
    logic             ref_rise;
    logic             dly_rise;
    logic [CNT_W-1:0] cnt;
    logic [LAP_W-1:0] m_q;
    logic [LAP_W-1:0] prev_m;
    logic [MC_W-1:0]  match_cnt;
    logic [MC_W-1:0]  match_nxt;

    // Identical register stages on both paths keep the relative delay exact.
    assign ref_rise = ref_q & ~ref_p;
    assign dly_rise = dly_q & ~dly_p;
    assign o_busy   = (state != IDLE);

    // Length of the run of equal measurements including the one in m_q.
    always_comb begin
        match_nxt = MC_W'(1);
        if (match_cnt != '0 && m_q == prev_m) begin
            match_nxt = match_cnt + MC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ref_q      <= 1'b0;
            ref_p      <= 1'b0;
            dly_q      <= 1'b0;
            dly_p      <= 1'b0;
            cnt        <= '0;
            m_q        <= '0;
            prev_m     <= '0;
            match_cnt  <= '0;
            o_delaylap <= '0;
            o_locked   <= 1'b0;
            o_err_tmo  <= 1'b0;
        end else begin
            ref_q <= i_ref_sync;
            ref_p <= ref_q;
            dly_q <= i_dly_sync;
            dly_p <= dly_q;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_locked  <= 1'b0;
                        o_err_tmo <= 1'b0;
                        match_cnt <= '0;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (ref_rise && dly_rise) begin
                        m_q   <= '0;
                        state <= EVAL;
                    end else if (ref_rise) begin
                        cnt   <= CNT_W'(1);
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // A dly edge on the last legal cycle still counts as a measurement.
                    if (dly_rise) begin
                        m_q   <= LAP_W'(cnt);
                        state <= EVAL;
                    end else if (cnt == CNT_W'(MAX_DELAY_LAPS)) begin
                        o_err_tmo <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    prev_m    <= m_q;
                    match_cnt <= match_nxt;
                    if (match_nxt >= MC_W'(LOCK_COUNT)) begin
                        o_delaylap <= m_q;
                        o_locked   <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_lap_calib.sv
// Directed and randomized bench for delay_lap_calib against a history-based
// reference model of the lock rule.
module tb_delay_lap_calib;

    localparam int MAX = 640;
    localparam int LC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_ref_sync = 1'b0;
    logic       i_dly_sync = 1'b0;
    logic [9:0] o_delaylap;
    logic       o_locked;
    logic       o_busy;
    logic       o_err_tmo;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int exp_lap    = 0;
    bit exp_locked = 1'b0;
    bit exp_err    = 1'b0;
    bit mbusy      = 1'b0;
    int hist[$];

    delay_lap_calib dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_ref_sync (i_ref_sync),
        .i_dly_sync (i_dly_sync),
        .o_delaylap (o_delaylap),
        .o_locked   (o_locked),
        .o_busy     (o_busy),
        .o_err_tmo  (o_err_tmo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".lap"},    32'(o_delaylap), 32'(exp_lap));
        check({tag, ".locked"}, 32'(o_locked),   32'(exp_locked));
        check({tag, ".busy"},   32'(o_busy),     32'(mbusy));
        check({tag, ".err"},    32'(o_err_tmo),  32'(exp_err));
    endtask

    task automatic model_reset();
        exp_lap = 0; exp_locked = 1'b0; exp_err = 1'b0; mbusy = 1'b0;
        hist.delete();
    endtask

    task automatic model_start();
        if (!mbusy) begin
            mbusy = 1'b1; exp_locked = 1'b0; exp_err = 1'b0;
            hist.delete();
        end
    endtask

    // Lock when the last LC measurements since start are all equal.
    task automatic model_meas(input int d);
        bit same;
        if (!mbusy) return;
        hist.push_back(d);
        if (hist.size() >= LC) begin
            same = 1'b1;
            for (int k = 1; k < LC; k++)
                if (hist[hist.size() - 1 - k] != d) same = 1'b0;
            if (same) begin
                exp_lap = d; exp_locked = 1'b1; mbusy = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_start(input string tag);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        model_start();
        check_all(tag);
    endtask

    // One ref pulse, dly pulse d cycles later; both w cycles wide.
    task automatic meas(input string tag, input int d, input int w, input int start_at);
        bit lk0;
        int lap0;
        lk0  = exp_locked;
        lap0 = exp_lap;
        for (int c = 0; c < d + w + 4; c++) begin
            i_ref_sync = (c < w);
            i_dly_sync = (c >= d && c < d + w);
            i_start    = (c == start_at);
            step();
            if (c == start_at) model_start();
            if (c == d + 1) begin
                check({tag, ".early_locked"}, 32'(o_locked), 32'(lk0));
                check({tag, ".early_lap"},    32'(o_delaylap), 32'(lap0));
            end
            if (c == d + 2) begin
                model_meas(d);
                check_all(tag);
            end
        end
        i_ref_sync = 1'b0;
        i_dly_sync = 1'b0;
        i_start    = 1'b0;
    endtask

    initial begin
        int base;
        int d;

        // Reset values
        rst = 1'b1;
        step();
        check_all("rst_held");
        repeat (2) step();
        rst = 1'b0;
        model_reset();
        step();
        check_all("rst_release");

        // Constant 37-cycle latency
        do_start("start37");
        repeat (4) meas("m37", 37, 3, -1);

        // 37 then four 38s: lock only after the fifth
        do_start("start38");
        meas("m37b", 37, 2, -1);
        repeat (4) meas("m38", 38, 2, -1);

        // Timeout keeps the old lap value
        do_start("start_tmo");
        for (int c = 0; c <= MAX + 1; c++) begin
            i_ref_sync = (c < 2);
            step();
            if (c == MAX) begin
                check("tmo_pre.busy", 32'(o_busy), 32'(1));
                check("tmo_pre.err",  32'(o_err_tmo), 32'(0));
            end
            if (c == MAX + 1) begin
                exp_err = 1'b1;
                mbusy   = 1'b0;
                check_all("tmo");
            end
        end
        repeat (2) step();

        // Zero latency: ref and dly tied
        do_start("start0");
        repeat (4) meas("m0", 0, 2, -1);

        // Largest legal measurement
        do_start("startmax");
        repeat (4) meas("mmax", MAX, 1, -1);

        // Randomized near-equal latencies
        for (int r = 0; r < 4; r++) begin
            do_reset(1);
            step();
            do_start("start_rnd");
            base = int'($urandom_range(1, 60));
            for (int i = 0; i < 7; i++) begin
                d = ($urandom_range(0, 3) == 0) ? base + 1 : base;
                meas("mrnd", d, int'($urandom_range(1, 4)), -1);
            end
        end
        do_reset(1);
        step();

        // i_start while busy must not restart or disturb the run count
        do_start("start_busy");
        meas("mb1", 20, 2, -1);
        meas("mb2", 20, 2, 5);
        meas("mb3", 20, 2, -1);
        meas("mb4", 20, 2, -1);

        // Reset mid-COUNT
        do_start("start_rst");
        for (int c = 0; c < 10; c++) begin
            i_ref_sync = (c < 2);
            step();
        end
        check("cnt_busy", 32'(o_busy), 32'(1));
        do_reset(1);
        check_all("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
